i2carbiter: RTL



---
 rtl/i2carb_pkg.sv | 17 +
 rtl/i2carbiter_rrpick.sv | 31 +++
 rtl/i2carbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/i2carb_pkg.sv
// rtl/i2carb_pkg.sv - shared types and constants for the i2c master arbiter
package i2carb_pkg;

  typedef enum logic [2:0] {IDLE, ISSUE, ARM, WAIT, DONE} state_t;

  localparam logic [1:0] OP_STOP    = 2'b00;
  localparam logic [1:0] OP_RESTART = 2'b01;
  localparam logic [1:0] OP_READ    = 2'b10;
  localparam logic [1:0] OP_WRITE   = 2'b11;

  localparam int BUSY = 63;
  localparam int ERR  = 62;

  // Clocks allowed in ARM for the master to raise busy after wrcmd
  localparam int ARM_CLKS = 4;

endpackage

// File: rtl/i2carbiter_rrpick.sv
// rtl/i2carbiter_rrpick.sv - combinational round-robin picker
module rrpick
  import i2carb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] reqs,
  input  logic [IW-1:0]   last,
  output logic            valid,
  output logic [IW-1:0]   winner
);

  logic [IW:0] cand;

  // Scan last+1 .. last+NREQ modulo NREQ; the first requester found wins
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, last} + (IW+1)'(k);
      if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
      if (!valid && reqs[cand[IW-1:0]]) begin
        valid  = 1'b1;
        winner = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/i2carbiter.sv
// rtl/i2carbiter.sv - round-robin sequencer sharing one i2c master between NREQ requesters
module i2carbiter
  import i2carb_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int TOBITS = 24
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic [NREQ-1:0]    reqs,
  input  logic [NREQ*64-1:0] cmds,
  output logic [NREQ-1:0]    dones,
  output logic [63:0]        rspdata,
  output logic               rsperr,
  output logic [NREQ-1:0]    grant,
  output logic               busy,
  output logic               wrcmd,
  output logic [63:0]        command,
  input  logic [63:0]        status,
  output logic               mreset
);

  localparam int IW = $clog2(NREQ);

  state_t            state_q, state_d;
  logic [IW-1:0]     last_q, last_d;
  logic [TOBITS-1:0] wd_q, wd_d;
  logic [NREQ-1:0]   dones_q, dones_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [63:0]       rspdata_q, rspdata_d;
  logic [63:0]       command_q, command_d;
  logic              rsperr_q, rsperr_d;
  logic              busy_q, busy_d;
  logic              wrcmd_q, wrcmd_d;
  logic              mreset_q, mreset_d;
  logic              fin_ok, fin_to;
  logic              pick_valid;
  logic [IW-1:0]     pick_idx;

  rrpick #(.NREQ(NREQ), .IW(IW)) u_rrpick (
    .reqs   (reqs),
    .last   (last_q),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    wd_d      = wd_q;
    dones_d   = '0;
    grant_d   = grant_q;
    rspdata_d = rspdata_q;
    command_d = command_q;
    rsperr_d  = rsperr_q;
    busy_d    = busy_q;
    wrcmd_d   = 1'b0;
    mreset_d  = 1'b0;
    fin_ok    = 1'b0;
    fin_to    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          last_d    = pick_idx;
          command_d = cmds[{pick_idx, 6'b0} +: 64];
          grant_d   = NREQ'(1) << pick_idx;
          busy_d    = 1'b1;
          wrcmd_d   = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = ARM;
      end
      ARM: begin
        if (status[BUSY]) begin
          wd_d    = '0;
          state_d = WAIT;
        end else if (wd_q == TOBITS'(ARM_CLKS - 1)) begin
          fin_to = 1'b1;
        end else begin
          wd_d = wd_q + TOBITS'(1);
        end
      end
      WAIT: begin
        if (!status[BUSY]) fin_ok = 1'b1;
        else if (&wd_q)    fin_to = 1'b1;
        else               wd_d   = wd_q + TOBITS'(1);
      end
      DONE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (fin_ok) begin
      rspdata_d = status;
      rsperr_d  = status[ERR];
    end
    // Timeout reports the master's last status with the error bit forced
    if (fin_to) begin
      rspdata_d      = status;
      rspdata_d[ERR] = 1'b1;
      rsperr_d       = 1'b1;
      mreset_d       = 1'b1;
    end
    if (fin_ok || fin_to) begin
      dones_d = grant_q;
      state_d = DONE;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q   <= IDLE;
      last_q    <= IW'(NREQ - 1);
      wd_q      <= '0;
      dones_q   <= '0;
      grant_q   <= '0;
      rspdata_q <= '0;
      command_q <= '0;
      rsperr_q  <= 1'b0;
      busy_q    <= 1'b0;
      wrcmd_q   <= 1'b0;
      mreset_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      wd_q      <= wd_d;
      dones_q   <= dones_d;
      grant_q   <= grant_d;
      rspdata_q <= rspdata_d;
      command_q <= command_d;
      rsperr_q  <= rsperr_d;
      busy_q    <= busy_d;
      wrcmd_q   <= wrcmd_d;
      mreset_q  <= mreset_d;
    end
  end

  assign dones   = dones_q;
  assign rspdata = rspdata_q;
  assign rsperr  = rsperr_q;
  assign grant   = grant_q;
  assign busy    = busy_q;
  assign wrcmd   = wrcmd_q;
  assign command = command_q;
  assign mreset  = mreset_q;

endmodule
